teknofest_ram_arbiter: RTL and testbench
========================================

TEKNOFEST_RAM_ARBITER -- requirements
Module: teknofest_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, word-address width into the RAM.
REQ-002 SHALL have parameter RAM_DEPTH, default 131072, number of valid 32-bit words.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port prog_busy_i, input, 1, the UART programmer owns the RAM; no grants while high.
REQ-006 SHALL have ports ins_req_i (1), ins_addr_i (ADDR_W), inputs, instruction-fetch read request and word address.
REQ-007 SHALL have ports ins_gnt_o (1), ins_rvalid_o (1), ins_rdata_o (32), outputs, fetch grant, response valid and read data.
REQ-008 SHALL have ports dat_req_i (1), dat_we_i (1), dat_addr_i (ADDR_W), dat_wdata_i (32), dat_wstrb_i (4), inputs, load/store request.
REQ-009 SHALL have ports dat_gnt_o (1), dat_rvalid_o (1), dat_rdata_o (32), dat_err_o (1), outputs, data grant, response, read data and address error.
REQ-010 SHALL have outputs ram_rd_en_o (1), ram_rd_addr_o (ADDR_W), ram_wr_addr_o (ADDR_W), ram_wr_data_o (32), ram_wr_strb_o (4), and input ram_rd_data_i (32), to the single-port RAM with 1-cycle read latency.

Function
REQ-011 SHALL grant at most one requester per cycle; gnt is combinational in the same cycle as req.
REQ-012 SHALL hold a request pending: a requester keeps req and address stable until gnt is seen.
REQ-013 SHALL grant nothing and drive ram_rd_en_o=0, ram_wr_strb_o=0 while prog_busy_i=1; pending requests wait.
REQ-014 SHALL, on an instruction grant, drive ram_rd_en_o=1 and ram_rd_addr_o=ins_addr_i.
REQ-015 SHALL, on a data read grant, drive ram_rd_en_o=1 and ram_rd_addr_o=dat_addr_i.
REQ-016 SHALL, on a data write grant, drive ram_wr_addr_o=dat_addr_i, ram_wr_data_o=dat_wdata_i, ram_wr_strb_o=dat_wstrb_i.
REQ-017 SHALL drive ram_wr_strb_o=0 in every cycle without a data write grant.
REQ-018 SHALL track a registered response owner {NONE, INS, DAT_RD, DAT_WR, DAT_ERR}, loaded at each grant, otherwise NONE.
REQ-019 SHALL pulse ins_rvalid_o exactly one cycle after an instruction grant, with ins_rdata_o=ram_rd_data_i.
REQ-020 SHALL pulse dat_rvalid_o exactly one cycle after any data grant; for reads dat_rdata_o=ram_rd_data_i, for writes dat_rdata_o=0.
REQ-021 SHALL treat a data address >= RAM_DEPTH as an error: grant it, suppress RAM access, then dat_rvalid_o=1, dat_err_o=1, dat_rdata_o=0.
REQ-022 SHALL treat an instruction address >= RAM_DEPTH as a normal read; wrapped data is returned without error.
REQ-023 SHALL drive rdata outputs to 0 when the matching rvalid is 0.
REQ-024 SHALL acknowledge a write with dat_wstrb_i=0 normally while the RAM is left unchanged.
REQ-025 SHALL support back-to-back grants every cycle; throughput is one access per cycle.

Reset
REQ-026 SHALL, while rst_ni=0 at a clock edge, clear the response owner to NONE and the last-grant register to INS.
REQ-027 SHALL have all gnt, rvalid, err and rdata outputs at 0 and ram_rd_en_o=0, ram_wr_strb_o=0 in the cycle after reset.
REQ-028 SHALL drop an in-flight response when reset is asserted mid-operation; no rvalid is issued after reset.

Configuration
REQ-029 SHALL, with macro TEKNOFEST_ARB_ROUND_ROBIN_EN defined, grant the requester not granted last when both request, and update last-grant on every grant.
REQ-030 SHALL, without TEKNOFEST_ARB_ROUND_ROBIN_EN, always grant data over instruction on conflict, with no last-grant register.

Verification
REQ-031 SHALL check: ins_req_i=1, addr 0x10, RAM word 0x00000013 -> ins_gnt_o same cycle, ins_rvalid_o next cycle, ins_rdata_o=0x00000013.
REQ-032 SHALL check: dat write addr 0x20, wdata 0xDEADBEEF, wstrb 0b0011 -> ram_wr_strb_o=0b0011, dat_rvalid_o next cycle; readback shows 0x????BEEF with upper half preserved.
REQ-033 SHALL check: both requesting for 4 cycles -> grants D,I,D,I with RR enabled, and D,D,D,D with RR disabled (instruction starved).
REQ-034 SHALL check: prog_busy_i=1 for 10 cycles with both requesting -> no gnt, no RAM strobes; first grant in the cycle prog_busy_i falls.
REQ-035 SHALL check: data read addr 131072 -> dat_gnt_o=1, ram_rd_en_o=0, next cycle dat_rvalid_o=1, dat_err_o=1, dat_rdata_o=0.
REQ-036 SHALL check: rst_ni=0 in the cycle after a grant -> no rvalid follows; all outputs are 0.

Source files
------------

// File: rtl/teknofest_ram_arbiter.sv
// Purpose: arbitrates an instruction-fetch port and a load/store port onto one single-port RAM.
// Latency: grant is combinational with req; rvalid/rdata follow exactly one cycle after the grant.
// Backpressure: no grants during reset or while prog_busy_i; a losing requester holds req until granted.
// Option: define TEKNOFEST_ARB_ROUND_ROBIN_EN for round-robin on conflict (default: data wins).
module teknofest_ram_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int RAM_DEPTH = 131072
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_busy_i,
  // instruction fetch port
  input  logic              ins_req_i,
  input  logic [ADDR_W-1:0] ins_addr_i,
  output logic              ins_gnt_o,
  output logic              ins_rvalid_o,
  output logic [31:0]       ins_rdata_o,
  // load/store port
  input  logic              dat_req_i,
  input  logic              dat_we_i,
  input  logic [ADDR_W-1:0] dat_addr_i,
  input  logic [31:0]       dat_wdata_i,
  input  logic [3:0]        dat_wstrb_i,
  output logic              dat_gnt_o,
  output logic              dat_rvalid_o,
  output logic [31:0]       dat_rdata_o,
  output logic              dat_err_o,
  // single-port RAM, 1-cycle read latency
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [31:0]       ram_wr_data_o,
  output logic [3:0]        ram_wr_strb_o,
  input  logic [31:0]       ram_rd_data_i
);

  // Who the RAM response in the next cycle belongs to.
  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_INS,
    OWN_DAT_RD,
    OWN_DAT_WR,
    OWN_DAT_ERR
  } owner_e;

  // One bit wider than the address so a depth equal to 2**ADDR_W never matches.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(RAM_DEPTH);

  owner_e owner_q, owner_d;
  logic   ins_gnt, dat_gnt;
  logic   dat_addr_bad;
  logic   dat_wr_go;

`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
  // 1 when the data port received the most recent grant.
  logic last_dat_q, last_dat_d;
`endif

  // Registered response owner (and last-grant memory when round-robin is built in).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= OWN_NONE;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat_q <= 1'b0;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat_q <= last_dat_d;
`endif
    end
  end

  // Grant selection, next owner, RAM command and response outputs.
  always_comb begin
    ins_gnt       = 1'b0;
    dat_gnt       = 1'b0;
    owner_d       = OWN_NONE;
    dat_addr_bad  = ({1'b0, dat_addr_i} >= DEPTH_LIM);
    dat_wr_go     = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_rd_addr_o = ins_addr_i;
    ram_wr_addr_o = '0;
    ram_wr_data_o = '0;
    ram_wr_strb_o = 4'b0000;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
    last_dat_d    = last_dat_q;
`endif

    // Nothing is granted while the programmer owns the RAM or reset is held.
    if (rst_ni && !prog_busy_i) begin
      if (ins_req_i && dat_req_i) begin
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
        if (last_dat_q) begin
          ins_gnt = 1'b1;
        end else begin
          dat_gnt = 1'b1;
        end
`else
        dat_gnt = 1'b1;
`endif
      end else begin
        ins_gnt = ins_req_i;
        dat_gnt = dat_req_i;
      end
    end

    if (ins_gnt) begin
      owner_d       = OWN_INS;
      ram_rd_en_o   = 1'b1;
      ram_rd_addr_o = ins_addr_i;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat_d    = 1'b0;
`endif
    end else if (dat_gnt) begin
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat_d = 1'b1;
`endif
      // Out-of-range data accesses are granted but never reach the RAM.
      if (dat_addr_bad) begin
        owner_d = OWN_DAT_ERR;
      end else if (dat_we_i) begin
        owner_d   = OWN_DAT_WR;
        dat_wr_go = 1'b1;
      end else begin
        owner_d       = OWN_DAT_RD;
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = dat_addr_i;
      end
    end

    if (dat_wr_go) begin
      ram_wr_addr_o = dat_addr_i;
      ram_wr_data_o = dat_wdata_i;
      ram_wr_strb_o = dat_wstrb_i;
    end

    ins_gnt_o = ins_gnt;
    dat_gnt_o = dat_gnt;

    // Responses are masked while reset is held so an in-flight access is dropped silently.
    ins_rvalid_o = rst_ni && (owner_q == OWN_INS);
    dat_rvalid_o = rst_ni && ((owner_q == OWN_DAT_RD) || (owner_q == OWN_DAT_WR) ||
                              (owner_q == OWN_DAT_ERR));
    dat_err_o    = rst_ni && (owner_q == OWN_DAT_ERR);
    ins_rdata_o  = (rst_ni && (owner_q == OWN_INS))    ? ram_rd_data_i : 32'h0;
    dat_rdata_o  = (rst_ni && (owner_q == OWN_DAT_RD)) ? ram_rd_data_i : 32'h0;
  end

endmodule

// File: tb/tb_teknofest_ram_arbiter.sv
// Purpose: randomized + directed scoreboard bench for teknofest_ram_arbiter.
// Latency: expects gnt in the request cycle and the response exactly one cycle later.
// Backpressure: requests are held until granted; prog_busy_i is pulsed to stall grants.
module tb_teknofest_ram_arbiter;

  localparam int AW    = 18;
  localparam int DEPTH = 131072;

  logic          clk;
  logic          rst_ni;
  logic          prog_busy_i;
  logic          ins_req_i;
  logic [AW-1:0] ins_addr_i;
  logic          ins_gnt_o, ins_rvalid_o;
  logic [31:0]   ins_rdata_o;
  logic          dat_req_i, dat_we_i;
  logic [AW-1:0] dat_addr_i;
  logic [31:0]   dat_wdata_i;
  logic [3:0]    dat_wstrb_i;
  logic          dat_gnt_o, dat_rvalid_o, dat_err_o;
  logic [31:0]   dat_rdata_o;
  logic          ram_rd_en_o;
  logic [AW-1:0] ram_rd_addr_o, ram_wr_addr_o;
  logic [31:0]   ram_wr_data_o;
  logic [3:0]    ram_wr_strb_o;
  logic [31:0]   ram_rd_data;

  teknofest_ram_arbiter #(.ADDR_W(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .prog_busy_i(prog_busy_i),
    .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_gnt_o(ins_gnt_o),
    .ins_rvalid_o(ins_rvalid_o), .ins_rdata_o(ins_rdata_o),
    .dat_req_i(dat_req_i), .dat_we_i(dat_we_i), .dat_addr_i(dat_addr_i),
    .dat_wdata_i(dat_wdata_i), .dat_wstrb_i(dat_wstrb_i), .dat_gnt_o(dat_gnt_o),
    .dat_rvalid_o(dat_rvalid_o), .dat_rdata_o(dat_rdata_o), .dat_err_o(dat_err_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o),
    .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_wr_strb_o(ram_wr_strb_o), .ram_rd_data_i(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  rsp_t        iq[$];
  rsp_t        dq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [1:0]  obs_gnt;
  bit          expect_quiet;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
  bit          last_dat;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h0000_0013;
    if (i == 32) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return AW'(DEPTH + int'($urandom_range(0, 63)));
    return AW'($urandom_range(0, 63));
  endfunction

  // Environment RAM: byte-strobed writes, one-cycle registered read, index wraps at DEPTH.
  logic [31:0] mem [DEPTH];
  initial begin : ram_model
    logic [31:0] w;
    int          k;
    ram_rd_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_wr_strb_o != 4'b0000) begin
        k = idx(ram_wr_addr_o);
        w = mem[k];
        for (int b = 0; b < 4; b++)
          if (ram_wr_strb_o[b]) w[8*b +: 8] = ram_wr_data_o[8*b +: 8];
        mem[k] = w;
      end
      if (ram_rd_en_o) ram_rd_data <= mem[idx(ram_rd_addr_o)];
    end
  end

  // Response monitor: pops the scoreboard whenever a valid appears, checks idle zeros otherwise.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (ins_rvalid_o) begin
        if (iq.size() == 0) chk("ins_rvalid_unexpected", 1, 0);
        else begin
          e = iq.pop_front();
          chk("ins_rsp_cycle", cyc, e.due);
          chk("ins_rdata", ins_rdata_o, e.data);
        end
      end else begin
        chk("ins_rdata_idle", ins_rdata_o, 0);
        if (iq.size() > 0 && iq[0].due <= cyc) begin
          chk("ins_rvalid_missing", 0, 1);
          void'(iq.pop_front());
        end
      end
      if (dat_rvalid_o) begin
        if (dq.size() == 0) chk("dat_rvalid_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          chk("dat_rsp_cycle", cyc, e.due);
          chk("dat_rdata_err", {dat_rdata_o, dat_err_o}, {e.data, e.err});
        end
      end else begin
        chk("dat_idle_zero", {dat_rdata_o, dat_err_o}, 0);
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          chk("dat_rvalid_missing", 0, 1);
          void'(dq.pop_front());
        end
      end
    end
  end

  // One cycle: predict the grant from the arbitration rules, check the combinational side,
  // queue the expected response, then retire granted requests after the edge.
  task automatic step();
    bit          ei, ed, bad, exp_rd;
    logic [3:0]  exp_strb;
    logic [31:0] w;
    int          k;
    @(negedge clk);
    ei  = 1'b0;
    ed  = 1'b0;
    bad = int'(dat_addr_i) >= DEPTH;
    if (rst_ni && !prog_busy_i) begin
      if (ins_req_i && dat_req_i) begin
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
        if (last_dat) ei = 1'b1; else ed = 1'b1;
`else
        ed = 1'b1;
`endif
      end else begin
        ei = ins_req_i;
        ed = dat_req_i;
      end
    end
    obs_gnt = {ins_gnt_o, dat_gnt_o};
    chk("gnt", obs_gnt, {ei, ed});
    exp_rd   = ei || (ed && !dat_we_i && !bad);
    exp_strb = (ed && dat_we_i && !bad) ? dat_wstrb_i : 4'b0000;
    chk("ram_rd_en", ram_rd_en_o, exp_rd);
    if (exp_rd) chk("ram_rd_addr", ram_rd_addr_o, ei ? ins_addr_i : dat_addr_i);
    chk("ram_wr_strb", ram_wr_strb_o, exp_strb);
    if (exp_strb != 4'b0000) chk("ram_wr_addr_data", {ram_wr_addr_o, ram_wr_data_o},
                                 {dat_addr_i, dat_wdata_i});
    if (!rst_ni || expect_quiet) begin
      chk("quiet_ctrl", {ins_gnt_o, dat_gnt_o, ins_rvalid_o, dat_rvalid_o, dat_err_o,
                         ram_rd_en_o, ram_wr_strb_o}, 0);
      chk("quiet_rdata", {ins_rdata_o, dat_rdata_o}, 0);
    end
    if (ei) begin
      iq.push_back('{cyc + 1, ref_mem[idx(ins_addr_i)], 1'b0});
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat = 1'b0;
`endif
    end
    if (ed) begin
      if (bad) dq.push_back('{cyc + 1, 32'h0, 1'b1});
      else if (dat_we_i) begin
        k = idx(dat_addr_i);
        w = ref_mem[k];
        for (int b = 0; b < 4; b++)
          if (dat_wstrb_i[b]) w[8*b +: 8] = dat_wdata_i[8*b +: 8];
        ref_mem[k] = w;
        dq.push_back('{cyc + 1, 32'h0, 1'b0});
      end else dq.push_back('{cyc + 1, ref_mem[idx(dat_addr_i)], 1'b0});
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
      last_dat = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    if (ei) ins_req_i = 1'b0;
    if (ed) dat_req_i = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_ni      = 1'b0;
    ins_req_i   = 1'b0;
    dat_req_i   = 1'b0;
    prog_busy_i = 1'b0;
    iq.delete();
    dq.delete();
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
    last_dat = 1'b0;
`endif
    for (int i = 0; i < n; i++) step();
    rst_ni       = 1'b1;
    expect_quiet = 1'b1;
    step();
    expect_quiet = 1'b0;
  endtask

  task automatic dat_cmd(input bit we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
    dat_req_i   = 1'b1;
    dat_we_i    = we;
    dat_addr_i  = a;
    dat_wdata_i = wd;
    dat_wstrb_i = st;
  endtask

  initial begin : main
    logic [7:0] seq, seq_exp;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst_ni = 1'b0; prog_busy_i = 1'b0; expect_quiet = 1'b0;
    ins_req_i = 1'b0; ins_addr_i = '0;
    dat_req_i = 1'b0; dat_we_i = 1'b0; dat_addr_i = '0; dat_wdata_i = '0; dat_wstrb_i = '0;
    #1;
    apply_reset(2);

    // Conflict for 4 cycles straight after reset (last grant = instruction).
    seq = 8'h0;
`ifdef TEKNOFEST_ARB_ROUND_ROBIN_EN
    seq_exp = 8'b01_10_01_10;
`else
    seq_exp = 8'b01_01_01_01;
`endif
    for (int i = 0; i < 4; i++) begin
      ins_req_i = 1'b1; ins_addr_i = AW'(8);
      dat_cmd(1'b0, AW'(9), 32'h0, 4'h0);
      step();
      seq = {seq[5:0], obs_gnt};
    end
    chk("conflict_grant_sequence", seq, seq_exp);
    apply_reset(1);

    // Instruction fetch from word 0x10 holding 0x00000013.
    ins_req_i = 1'b1; ins_addr_i = AW'(16);
    step();
    // Half-word write, then read back with the upper half preserved.
    dat_cmd(1'b1, AW'(32), 32'hDEAD_BEEF, 4'b0011);
    step();
    dat_cmd(1'b0, AW'(32), 32'h0, 4'h0);
    step();
    step();

    // Programmer busy for 10 cycles with both requesting; grant as soon as it drops.
    prog_busy_i = 1'b1;
    ins_req_i = 1'b1; ins_addr_i = AW'(3);
    dat_cmd(1'b0, AW'(4), 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) step();
    prog_busy_i = 1'b0;
    step();
    step();
    step();

    // Out-of-range data read, out-of-range write and a wrapped instruction fetch.
    dat_cmd(1'b0, AW'(DEPTH), 32'h0, 4'h0);
    step();
    dat_cmd(1'b1, AW'(DEPTH + 7), 32'hFFFF_FFFF, 4'hF);
    step();
    ins_req_i = 1'b1; ins_addr_i = AW'(DEPTH + 16);
    step();
    // Zero-strobe write is acknowledged and leaves word 0x10 intact.
    dat_cmd(1'b1, AW'(16), 32'hFFFF_FFFF, 4'h0);
    step();
    ins_req_i = 1'b1; ins_addr_i = AW'(16);
    step();
    step();

    // Reset in the cycle after a grant: the response must never appear.
    ins_req_i = 1'b1; ins_addr_i = AW'(5);
    step();
    apply_reset(1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!ins_req_i && $urandom_range(0, 2) != 0) begin
        ins_req_i  = 1'b1;
        ins_addr_i = rnd_addr();
      end
      if (!dat_req_i && $urandom_range(0, 2) != 0)
        dat_cmd(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 4'($urandom_range(0, 15)));
      prog_busy_i = ($urandom_range(0, 19) == 0);
      step();
    end
    prog_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ins_req_i = 1'b0;
    dat_req_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rsp_queues_drained", iq.size() + dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
